// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, I-cache, D-cache and redirect requests.
// Latency: all controls are combinational from state and inputs; state, watchdog and perf counters update on posedge clk_i.
// Backpressure: D-cache freeze stalls the whole pipe; a redirect during an in-flight fetch drains it in IDRAIN before acking.
// Optional build macro STALL_PERF_CNT_EN enables the three 32-bit saturating perf counters (ports read 0 otherwise).
module pipeline_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_use_i,
  input  logic        icache_stall_i,
  input  logic        dcache_stall_i,
  input  logic        redirect_i,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        backend_stall_o,
  output logic        flush_ack_o,
  output logic        timeout_o,
  output logic        state_o,
  output logic [31:0] perf_loaduse_o,
  output logic [31:0] perf_freeze_o,
  output logic [31:0] perf_redirect_o
);

  typedef enum logic {
    RUN    = 1'b0,
    IDRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wd_cnt_q;
  logic [CNT_W-1:0] wd_cnt_d;
  logic             timeout_q;

  // State register; reset drops any pending drain since EX is reset too.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-stage controls; freeze overrides everything, then the RUN/IDRAIN rules.
  always_comb begin
    state_d         = state_q;
    pc_stall_o      = 1'b0;
    ifid_stall_o    = 1'b0;
    ifid_flush_o    = 1'b0;
    idex_bubble_o   = 1'b0;
    backend_stall_o = 1'b0;
    flush_ack_o     = 1'b0;
    if (rst_i) begin
      state_d       = RUN;
      pc_stall_o    = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (dcache_stall_i) begin
      // Whole pipe frozen; other requests stay valid and are served once the freeze lifts.
      pc_stall_o      = 1'b1;
      ifid_stall_o    = 1'b1;
      backend_stall_o = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (redirect_i && !icache_stall_i) begin
            flush_ack_o   = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end else if (redirect_i) begin
            // Fetch in flight: hold the redirecting branch in EX until the I-cache returns.
            pc_stall_o      = 1'b1;
            ifid_flush_o    = 1'b1;
            backend_stall_o = 1'b1;
            state_d         = IDRAIN;
          end else if (load_use_i) begin
            // IF/ID holds rather than flushes so the dependent ID instruction survives an I-cache miss.
            pc_stall_o    = 1'b1;
            ifid_stall_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end else if (icache_stall_i) begin
            pc_stall_o   = 1'b1;
            ifid_flush_o = 1'b1;
          end
        end
        IDRAIN: begin
          if (icache_stall_i) begin
            pc_stall_o      = 1'b1;
            ifid_flush_o    = 1'b1;
            backend_stall_o = 1'b1;
          end else begin
            // Returned instruction is wrong-path: discard it and let PC take the target.
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            flush_ack_o   = 1'b1;
            state_d       = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Watchdog next count: run length of consecutive PC-stalled cycles, saturating.
  always_comb begin
    wd_cnt_d = '0;
    if (pc_stall_o) begin
      wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter and sticky timeout flag, visible the cycle after the run length reaches the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_cnt_d >= WD_LIMIT) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q & ~rst_i;
  assign state_o   = (state_q == IDRAIN) & ~rst_i;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_q;
  logic [31:0] perf_fz_q;
  logic [31:0] perf_rd_q;
  logic        ev_loaduse;
  logic        ev_freeze;

  assign ev_loaduse = ~rst_i & ~dcache_stall_i & (state_q == RUN) & ~redirect_i & load_use_i;
  assign ev_freeze  = ~rst_i & dcache_stall_i;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_lu_q <= '0;
      perf_fz_q <= '0;
      perf_rd_q <= '0;
    end else begin
      if (ev_loaduse && perf_lu_q != '1) perf_lu_q <= perf_lu_q + 32'd1;
      if (ev_freeze && perf_fz_q != '1) perf_fz_q <= perf_fz_q + 32'd1;
      if (flush_ack_o && perf_rd_q != '1) perf_rd_q <= perf_rd_q + 32'd1;
    end
  end

  assign perf_loaduse_o  = rst_i ? 32'd0 : perf_lu_q;
  assign perf_freeze_o   = rst_i ? 32'd0 : perf_fz_q;
  assign perf_redirect_o = rst_i ? 32'd0 : perf_rd_q;
`else
  assign perf_loaduse_o  = 32'd0;
  assign perf_freeze_o   = 32'd0;
  assign perf_redirect_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, a reset-during-drain sequence, then random traffic vs a reference model.
// Inputs change 1ns after posedge; outputs sampled on negedge.
// Redirect is held until acked (or dropped by reset), matching the upstream contract.
module tb_pipeline_stall_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, lu, ic, dc, rd;
  logic        pc_stall, ifid_stall, ifid_flush, idex_bubble, backend_stall, flush_ack, timeout, state;
  logic [31:0] perf_lu, perf_fz, perf_rd;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending drain flag, stall run length, sticky timeout, event tallies.
  bit      m_drain = 0;
  int      m_run = 0;
  bit      m_tmo = 0;
  longint  m_lu = 0, m_fz = 0, m_rd = 0;

  typedef struct packed {
    logic [4:0] in;   // {rst, load_use, icache, dcache, redirect}
    logic [7:0] ex;   // {pc, ifid_stall, ifid_flush, bubble, backend, ack, state, timeout}
  } vec_t;

  vec_t tbl[$];

  pipeline_stall_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .load_use_i(lu), .icache_stall_i(ic),
    .dcache_stall_i(dc), .redirect_i(rd),
    .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .backend_stall_o(backend_stall), .flush_ack_o(flush_ack),
    .timeout_o(timeout), .state_o(state),
    .perf_loaduse_o(perf_lu), .perf_freeze_o(perf_fz), .perf_redirect_o(perf_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_out(input logic r, l, i, d, x);
    logic pc, fs, ff, bb, bk, ak;
    {pc, fs, ff, bb, bk, ak} = '0;
    if (r) begin
      pc = 1; ff = 1; bb = 1;
    end else if (d) begin
      pc = 1; fs = 1; bk = 1;
    end else if (m_drain) begin
      if (i) begin pc = 1; ff = 1; bk = 1; end
      else begin ff = 1; bb = 1; ak = 1; end
    end else if (x) begin
      if (!i) begin ak = 1; ff = 1; bb = 1; end
      else begin pc = 1; ff = 1; bk = 1; end
    end else if (l) begin
      pc = 1; fs = 1; bb = 1;
    end else if (i) begin
      pc = 1; ff = 1;
    end
    return {pc, fs, ff, bb, bk, ak, (!r && m_drain), (!r && m_tmo)};
  endfunction

  function automatic logic [95:0] model_perf(input logic r);
`ifdef STALL_PERF_CNT_EN
    if (r) return '0;
    return {m_lu[31:0], m_fz[31:0], m_rd[31:0]};
`else
    return {32'd0, 32'd0, 32'd0} | {95'd0, r & 1'b0};
`endif
  endfunction

  // One cycle: drive, compare on negedge (table value if given, else model), then advance the model at posedge.
  task automatic step(input logic [4:0] in, input bit use_tbl, input logic [7:0] tex,
                      input string nm, output bit acked);
    logic [7:0]  mexp, exp_v, act;
    logic [95:0] pexp, pact;
    bit          r, l, i, d, x;
    {r, l, i, d, x} = in;
    {rst, lu, ic, dc, rd} = in;
    @(negedge clk);
    mexp  = model_out(r, l, i, d, x);
    exp_v = use_tbl ? tex : mexp;
    act   = {pc_stall, ifid_stall, ifid_flush, idex_bubble, backend_stall, flush_ack, state, timeout};
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b want %b (in=%b)", nm, act, exp_v, in);
    end
    pexp = model_perf(r);
    pact = {perf_lu, perf_fz, perf_rd};
    n_cmp++;
    if (pact !== pexp) begin
      n_bad++;
      $display("FAIL %s perf: got %0d/%0d/%0d want %0d/%0d/%0d", nm,
               pact[95:64], pact[63:32], pact[31:0], pexp[95:64], pexp[63:32], pexp[31:0]);
    end
    acked = mexp[2];
    @(posedge clk);
    if (r) begin
      m_drain = 0; m_run = 0; m_tmo = 0; m_lu = 0; m_fz = 0; m_rd = 0;
    end else begin
      if (d) m_fz++;
      else if (!m_drain && !x && l) m_lu++;
      if (mexp[2]) m_rd++;
      if (!d) begin
        if (m_drain && !i) m_drain = 0;
        else if (!m_drain && x && i) m_drain = 1;
      end
      m_run = mexp[7] ? ((m_run < 65535) ? m_run + 1 : m_run) : 0;
      if (m_run >= TMO) m_tmo = 1;
    end
    #1;
  endtask

  task automatic add(input int n, input logic [4:0] in, input logic [7:0] ex);
    for (int k = 0; k < n; k++) tbl.push_back('{in: in, ex: ex});
  endtask

  initial begin
    bit   ack;
    bit   rd_pend;
    logic [4:0] rin;
    {rst, lu, ic, dc, rd} = 5'b10000;

    // reset, load-use with I-miss, redirect during in-flight fetch
    add(3, 5'b10000, 8'b1011_0000);
    add(1, 5'b00000, 8'b0000_0000);
    add(1, 5'b01100, 8'b1101_0000);
    add(1, 5'b00100, 8'b1010_0000);
    add(1, 5'b00101, 8'b1010_1000);
    add(3, 5'b00101, 8'b1010_1010);
    add(1, 5'b00001, 8'b0011_0110);
    add(1, 5'b00000, 8'b0000_0000);
    // freeze during IDRAIN while the I-cache returns
    add(1, 5'b00101, 8'b1010_1000);
    add(1, 5'b00111, 8'b1100_1010);
    add(4, 5'b00011, 8'b1100_1010);
    add(1, 5'b00001, 8'b0011_0110);
    add(1, 5'b00000, 8'b0000_0000);
    // watchdog: 10 I-miss cycles, timeout from the 9th, sticky until reset
    add(8, 5'b00100, 8'b1010_0000);
    add(2, 5'b00100, 8'b1010_0001);
    add(1, 5'b00000, 8'b0000_0001);
    add(1, 5'b10000, 8'b1011_0000);
    add(1, 5'b00000, 8'b0000_0000);
    // perf: 2 load-use, 4 freeze, 1 same-cycle redirect
    add(2, 5'b01000, 8'b1101_0000);
    add(4, 5'b00010, 8'b1100_1000);
    add(1, 5'b00001, 8'b0011_0100);
    add(1, 5'b00000, 8'b0000_0000);

    @(posedge clk);
    #1;
    for (int t = 0; t < tbl.size(); t++) begin
      step(tbl[t].in, 1, tbl[t].ex, $sformatf("vec%0d", t), ack);
    end

    n_cmp++;
`ifdef STALL_PERF_CNT_EN
    if ({perf_lu, perf_fz, perf_rd} !== {32'd2, 32'd4, 32'd1}) begin
`else
    if ({perf_lu, perf_fz, perf_rd} !== {32'd0, 32'd0, 32'd0}) begin
`endif
      n_bad++;
      $display("FAIL perf_totals: got %0d/%0d/%0d", perf_lu, perf_fz, perf_rd);
    end

    // reset while draining: pending redirect is dropped, no ack afterwards
    step(5'b00101, 1, 8'b1010_1000, "rst_drain0", ack);
    step(5'b00101, 1, 8'b1010_1010, "rst_drain1", ack);
    step(5'b10101, 1, 8'b1011_0000, "rst_drain2", ack);
    step(5'b00000, 1, 8'b0000_0000, "rst_drain3", ack);
    step(5'b00001, 1, 8'b0011_0100, "rst_drain4", ack);

    // random traffic vs model
    rd_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      rin[4] = ($urandom_range(0, 99) == 0);
      rin[3] = ($urandom_range(0, 3) == 0);
      rin[2] = ($urandom_range(0, 2) == 0);
      rin[1] = ($urandom_range(0, 5) == 0);
      rin[0] = rd_pend | ($urandom_range(0, 7) == 0);
      step(rin, 0, 8'h00, "rand", ack);
      rd_pend = rin[0] && !ack && !rin[4];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It merges four request sources into one consistent set of per-stage hold/flush/bubble controls:
- load-use request from the hazard detector;
- I-cache busy;
- D-cache busy;
- EX-stage branch redirect.

It owns the redirect handshake, including the case where a redirect lands while an I-cache fetch is in flight. It also runs a stall watchdog.

Parameters:
TIMEOUT_CYCLES, 1024, consecutive stalled cycles before timeout_o sets (1..2^CNT_W-1)
CNT_W, 16, watchdog counter width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
load_use_i  input  1  load-use hazard request (ID needs EX load result)
icache_stall_i  input  1  I-cache fetch not complete this cycle
dcache_stall_i  input  1  D-cache access not complete this cycle
redirect_i  input  1  EX branch/jump redirect request; level, held until flush_ack_o
pc_stall_o  output  1  hold PC
ifid_stall_o  output  1  hold IF/ID register
ifid_flush_o  output  1  load NOP into IF/ID
idex_bubble_o  output  1  load NOP control into ID/EX
backend_stall_o  output  1  hold ID/EX, EX/MEM, MEM/WB
flush_ack_o  output  1  redirect accepted; PC loads target this cycle
timeout_o  output  1  sticky watchdog flag
state_o  output  1  0=RUN, 1=IDRAIN
perf_loaduse_o  output  32  load-use bubble count
perf_freeze_o  output  32  D-cache freeze cycle count
perf_redirect_o  output  32  accepted redirect count

Behaviour:
- Outputs are combinational from state and inputs. State, watchdog and perf counters are registered on posedge clk_i.
- rst_i=1:
  - Outputs: pc_stall_o=1, ifid_flush_o=1, idex_bubble_o=1; all other outputs 0.
  - Next state RUN; watchdog counter 0; timeout_o 0; perf counters 0.
  - Reset asserted in IDRAIN returns to RUN next cycle. The pending redirect is dropped; EX has been reset as well.
- Priority, highest first: freeze > RUN/IDRAIN rules.
- Freeze (dcache_stall_i=1, any state):
  - pc_stall_o=ifid_stall_o=backend_stall_o=1.
  - flush_ack_o=0, ifid_flush_o=0, idex_bubble_o=0.
  - State holds.
  - Other inputs ignored; they remain valid because the pipeline is frozen.
- RUN, no freeze, first match wins:
  - redirect_i & !icache_stall_i: flush_ack_o=1, ifid_flush_o=1, idex_bubble_o=1, pc_stall_o=0. Stay RUN.
  - redirect_i & icache_stall_i: backend_stall_o=1, pc_stall_o=1, ifid_flush_o=1, flush_ack_o=0. Next state IDRAIN.
  - load_use_i: pc_stall_o=1, ifid_stall_o=1, idex_bubble_o=1. Single cycle; repeats while load_use_i is held.
  - icache_stall_i: pc_stall_o=1, ifid_flush_o=1. Backend advances.
  - Otherwise: all outputs 0.
  - Note: load_use_i & icache_stall_i gives the load-use response. IF/ID holds, never flushes, so the ID instruction is kept.
- IDRAIN, no freeze. The in-flight fetch is wrong-path.
  - icache_stall_i=1: pc_stall_o=1, ifid_flush_o=1, backend_stall_o=1. Stay.
  - icache_stall_i=0: the returned instruction is discarded. Outputs ifid_flush_o=1, idex_bubble_o=1, flush_ack_o=1, pc_stall_o=0, backend_stall_o=0. Next state RUN.
  - load_use_i is ignored in IDRAIN; the ID instruction is wrong-path.
- Redirect accounting: exactly one flush_ack_o pulse per redirect. The same-cycle case pays 0 extra cycles; the in-flight-fetch case pays (remaining I-cache busy cycles + 1).
- Watchdog:
  - Counter increments each cycle in which pc_stall_o=1 and rst_i=0; clears on any cycle with pc_stall_o=0.
  - Saturates at 2^CNT_W-1.
  - timeout_o sets on the cycle after the count reaches TIMEOUT_CYCLES. It stays set until rst_i.

Optional Feature:
STALL_PERF_CNT_EN:
- Defined: the three 32-bit perf counters are implemented, each saturating at 0xFFFFFFFF and cleared by rst_i.
  - perf_loaduse_o increments on load-use response cycles.
  - perf_freeze_o increments on freeze cycles.
  - perf_redirect_o increments on flush_ack_o cycles.
- Undefined: the counters are not implemented and all three ports drive constant 0. Ports remain, so the interface is unchanged.

Test Plan:
- Reset held 3 cycles, then released, no requests -> during reset pc_stall_o=1, ifid_flush_o=1, idex_bubble_o=1; first cycle after release all outputs 0, state_o=0, timeout_o=0.
- load_use_i=1 for 1 cycle with icache_stall_i=1 -> pc_stall_o=1, ifid_stall_o=1, ifid_flush_o=0, idex_bubble_o=1; next cycle (load_use_i=0, icache_stall_i=1) -> ifid_flush_o=1, ifid_stall_o=0.
- redirect_i=1 with icache_stall_i=1 for 3 more cycles -> state_o=1 for 3 cycles with backend_stall_o=1; on the cycle icache_stall_i=0: flush_ack_o=1, ifid_flush_o=1, idex_bubble_o=1; exactly one ack; state_o=0 next cycle.
- dcache_stall_i=1 for 5 cycles during IDRAIN, concurrent with icache_stall_i falling -> 5 freeze cycles, flush_ack_o=0, state_o stays 1; ack on first cycle after dcache_stall_i=0.
- TIMEOUT_CYCLES=8, icache_stall_i=1 for 10 cycles -> timeout_o rises after 8 stalled cycles, stays 1 after stall ends, clears only on rst_i.
- With STALL_PERF_CNT_EN: 2 load-use, 4 freeze cycles, 1 redirect -> perf counters read 2/4/1. Without the macro -> all read 0.
